// File: rtl/mc_alu_unit.sv
// mc_alu_unit: multicycle ALU execution unit with a start/done handshake.
//
// Single-cycle ops (ADD, LT, LE, NE, AND, OR, XOR, EQ, SUB, NAND, NOR, NXOR) finish one cycle
// after start. Shifts (SLL, SRL, SRA) move one bit per cycle. MUL is an iterative shift-add
// that is only built when MC_ALU_MUL_EN is defined. Without it, func F finishes in one cycle
// with result 0 and err 1.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-high reset
//   start   in   request, sampled only while busy is low
//   func    in   operation code, latched with start
//   a, b    in   signed operands, latched with start (b[SHBITS-1:0] is the shift amount)
//   busy    out  high while a multicycle op is in flight (low in the done cycle)
//   done    out  one-cycle completion pulse
//   result  out  registered result, held until the next completion
//   cmp     out  result[0], for branch decisions
//   err     out  one-cycle pulse with done for an unsupported func
module mc_alu_unit #(
  parameter int unsigned DBITS    = 32,
  parameter int unsigned FUNCBITS = 4,
  parameter int unsigned SHBITS   = $clog2(DBITS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [FUNCBITS-1:0] func,
  input  logic [DBITS-1:0]    a,
  input  logic [DBITS-1:0]    b,
  output logic                busy,
  output logic                done,
  output logic [DBITS-1:0]    result,
  output logic                cmp,
  output logic                err
);

  // One extra bit so the counter can hold DBITS for MUL.
  localparam int unsigned CW = SHBITS + 1;

  localparam logic [FUNCBITS-1:0] FnAdd  = FUNCBITS'(0);
  localparam logic [FUNCBITS-1:0] FnLt   = FUNCBITS'(1);
  localparam logic [FUNCBITS-1:0] FnLe   = FUNCBITS'(2);
  localparam logic [FUNCBITS-1:0] FnNe   = FUNCBITS'(3);
  localparam logic [FUNCBITS-1:0] FnAnd  = FUNCBITS'(4);
  localparam logic [FUNCBITS-1:0] FnOr   = FUNCBITS'(5);
  localparam logic [FUNCBITS-1:0] FnXor  = FUNCBITS'(6);
  localparam logic [FUNCBITS-1:0] FnEq   = FUNCBITS'(7);
  localparam logic [FUNCBITS-1:0] FnSub  = FUNCBITS'(8);
  localparam logic [FUNCBITS-1:0] FnSll  = FUNCBITS'(9);
  localparam logic [FUNCBITS-1:0] FnSrl  = FUNCBITS'(10);
  localparam logic [FUNCBITS-1:0] FnSra  = FUNCBITS'(11);
  localparam logic [FUNCBITS-1:0] FnNand = FUNCBITS'(12);
  localparam logic [FUNCBITS-1:0] FnNor  = FUNCBITS'(13);
  localparam logic [FUNCBITS-1:0] FnNxor = FUNCBITS'(14);
  localparam logic [FUNCBITS-1:0] FnMul  = FUNCBITS'(15);

  typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

  state_e                state_q;
  logic [FUNCBITS-1:0]   op_q;
  logic [DBITS-1:0]      acc_q;
  logic [CW-1:0]         cnt_q;
  logic [DBITS-1:0]      result_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic [DBITS-1:0]      alu_out;
  logic                  alu_err;
  logic [DBITS-1:0]      shift_next;
  logic                  is_shift;
  logic [SHBITS-1:0]     sh_amt;

  assign sh_amt   = b[SHBITS-1:0];
  assign is_shift = (func == FnSll) || (func == FnSrl) || (func == FnSra);

  // Results of everything that completes at the accepting edge.
  always_comb begin
    alu_out = '0;
    alu_err = 1'b0;
    case (func)
      FnAdd:  alu_out = a + b;
      FnLt:   alu_out = DBITS'($signed(a) < $signed(b));
      FnLe:   alu_out = DBITS'($signed(a) <= $signed(b));
      FnNe:   alu_out = DBITS'(a != b);
      FnAnd:  alu_out = a & b;
      FnOr:   alu_out = a | b;
      FnXor:  alu_out = a ^ b;
      FnEq:   alu_out = DBITS'(a == b);
      FnSub:  alu_out = a - b;
      // Shift by zero completes immediately with the operand unchanged.
      FnSll, FnSrl, FnSra: alu_out = a;
      FnNand: alu_out = ~(a & b);
      FnNor:  alu_out = ~(a | b);
      FnNxor: alu_out = ~(a ^ b);
      FnMul: begin
`ifndef MC_ALU_MUL_EN
        alu_err = 1'b1;
`endif
      end
      default: alu_err = 1'b1;
    endcase
  end

  // One-bit step of the iterative shifter.
  always_comb begin
    shift_next = acc_q;
    case (op_q)
      FnSll:   shift_next = {acc_q[DBITS-2:0], 1'b0};
      FnSrl:   shift_next = {1'b0, acc_q[DBITS-1:1]};
      default: shift_next = {acc_q[DBITS-1], acc_q[DBITS-1:1]};
    endcase
  end

`ifdef MC_ALU_MUL_EN
  logic [DBITS-1:0] mcand_q;
  logic [DBITS-1:0] mplier_q;
  logic [DBITS-1:0] mul_sum;

  // Partial product: add the shifted multiplicand when the current multiplier bit is set.
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef MC_ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q <= func;
            if (is_shift && (sh_amt != '0)) begin
              state_q <= StShift;
              acc_q   <= a;
              cnt_q   <= CW'(sh_amt);
              busy_q  <= 1'b1;
`ifdef MC_ALU_MUL_EN
            end else if (func == FnMul) begin
              state_q  <= StMul;
              acc_q    <= '0;
              mcand_q  <= a;
              mplier_q <= b;
              cnt_q    <= CW'(DBITS);
              busy_q   <= 1'b1;
`endif
            end else begin
              result_q <= alu_out;
              done_q   <= 1'b1;
              err_q    <= alu_err;
            end
          end
        end
        StShift: begin
          acc_q <= shift_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q <= shift_next;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
`ifdef MC_ALU_MUL_EN
        StMul: begin
          acc_q    <= mul_sum;
          mcand_q  <= {mcand_q[DBITS-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[DBITS-1:1]};
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q <= mul_sum;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign cmp    = result_q[0];

endmodule

// File: tb/tb_mc_alu_unit.sv
// Self-checking bench for mc_alu_unit (DBITS=32). Expected values come from a plain
// arithmetic model of each func code. Follows MC_ALU_MUL_EN for the MUL expectations.
module tb_mc_alu_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  func;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cmp;
  logic        err;

  int total = 0;
  int bad   = 0;

  mc_alu_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .func   (func),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cmp    (cmp),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: result, err and start->done latency for one operation.
  task automatic model(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic e, output int lat);
    int sh;
    sh  = int'(y % 32);
    r   = 32'd0;
    e   = 1'b0;
    lat = 1;
    case (f)
      4'h0: r = x + y;
      4'h1: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'h2: r = ($signed(x) <= $signed(y)) ? 32'd1 : 32'd0;
      4'h3: r = (x != y) ? 32'd1 : 32'd0;
      4'h4: r = x & y;
      4'h5: r = x | y;
      4'h6: r = x ^ y;
      4'h7: r = (x == y) ? 32'd1 : 32'd0;
      4'h8: r = x - y;
      4'h9: r = x << sh;
      4'hA: r = x >> sh;
      4'hB: r = $signed(x) >>> sh;
      4'hC: r = ~(x & y);
      4'hD: r = ~(x | y);
      4'hE: r = ~(x ^ y);
      default: begin
`ifdef MC_ALU_MUL_EN
        r   = x * y;
        lat = 33;
`else
        e = 1'b1;
`endif
      end
    endcase
    if (f >= 4'h9 && f <= 4'hB && sh != 0) lat = sh + 1;
  endtask

  // Issue one op, scramble inputs after the accepting edge, wait (bounded) for done.
  task automatic do_op(input string tag, input logic [3:0] f, input logic [31:0] x,
                       input logic [31:0] y);
    logic [31:0] er;
    logic        ee;
    int          el;
    int          lat;
    model(f, x, y, er, ee, el);
    @(negedge clk);
    start = 1'b1; func = f; a = x; b = y;
    @(negedge clk);
    start = 1'b0; func = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    check({tag, "_busy1"}, 32'(busy), 32'(el > 1));
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(el));
    check({tag, "_res"}, result, er);
    check({tag, "_err"}, 32'(err), 32'(ee));
    check({tag, "_cmp"}, 32'(cmp), 32'(er[0]));
    check({tag, "_busydone"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] er;
    logic        ee;
    int          el;
    int          pulses;
    logic [3:0]  abort_f;
    logic [31:0] abort_b;

    reset = 1'b1; start = 1'b0; func = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_cmp", 32'(cmp), 32'd0);
    reset = 1'b0;

    // Directed compare ops
    do_op("lt", 4'h1, 32'hFFFF_FFFF, 32'd1);
    check("lt_const", result, 32'd1);
    do_op("le", 4'h2, 32'd7, 32'd7);
    do_op("ne", 4'h3, 32'h5, 32'h5);
    check("ne_const", result, 32'd0);

    // Shifts, including upper bits of b ignored and the maximum amount
    do_op("sra", 4'hB, 32'h8000_0000, 32'd4);
    check("sra_const", result, 32'hF800_0000);
    do_op("srl_hi", 4'hA, 32'hF000_000F, 32'h24);
    check("srl_const", result, 32'h0F00_0000);
    do_op("sll31", 4'h9, 32'h3, 32'd31);
    do_op("sll0", 4'h9, 32'h1234_5678, 32'h40);

    // MUL (or its disabled behaviour)
    do_op("mul", 4'hF, 32'hFFFF_FFFF, 32'd3);

    // start held during a shift is ignored; start in the done cycle is accepted
    @(negedge clk);
    start = 1'b1; func = 4'h9; a = 32'h0000_0005; b = 32'd3;
    @(negedge clk);
    check("hold_busy", 32'(busy), 32'd1);
    func = 4'h0; a = 32'd10; b = 32'd20;
    @(negedge clk);
    check("hold_nodone2", 32'(done), 32'd0);
    @(negedge clk);
    check("hold_nodone3", 32'(done), 32'd0);
    @(negedge clk);
    check("hold_done", 32'(done), 32'd1);
    check("hold_res", result, 32'h0000_0028);
    check("hold_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("redo_done", 32'(done), 32'd1);
    check("redo_res", result, 32'd30);

    // Back-to-back single-cycle ops: ADD, SUB, XOR
    @(negedge clk);
    start = 1'b1; func = 4'h0; a = 32'd100; b = 32'd23;
    @(negedge clk);
    check("b2b_add_done", 32'(done), 32'd1);
    check("b2b_add_res", result, 32'd123);
    func = 4'h8; a = 32'd5; b = 32'd9;
    @(negedge clk);
    check("b2b_sub_done", 32'(done), 32'd1);
    check("b2b_sub_res", result, 32'hFFFF_FFFC);
    func = 4'h6; a = 32'hFF00_FF00; b = 32'h0F0F_0F0F;
    @(negedge clk);
    start = 1'b0;
    check("b2b_xor_done", 32'(done), 32'd1);
    check("b2b_xor_res", result, 32'hF00F_F00F);
    @(negedge clk);
    check("b2b_idle", 32'(done), 32'd0);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      do_op("rnd", 4'($urandom), $urandom, $urandom);
    end

    // Reset in the middle of a long op aborts it with no done pulse
`ifdef MC_ALU_MUL_EN
    abort_f = 4'hF; abort_b = 32'd7;
`else
    abort_f = 4'h9; abort_b = 32'd31;
`endif
    do_op("pre_abort", 4'h0, 32'd1, 32'd2);
    @(negedge clk);
    start = 1'b1; func = abort_f; a = 32'd9; b = abort_b;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_res", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_nopulse", 32'(pulses), 32'd0);
    do_op("post_add", 4'h0, 32'd2, 32'd3);
    check("post_add_const", result, 32'd5);

    model(4'hF, 32'hFFFF_FFFF, 32'd3, er, ee, el);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
